// File: rtl/cpu_pkg.sv
// cpu_pkg: values shared by the fetch, decode and redirect logic.
// Holds the opcode constants, the {C,N,Z} flag bit positions, the
// redirect FSM state encoding and a helper that maps a conditional
// branch opcode to the flag bit it tests.
package cpu_pkg;

  localparam logic [4:0] OP_CALL = 5'b00101;
  localparam logic [4:0] OP_RET  = 5'b00010;
  localparam logic [4:0] OP_RTI  = 5'b00011;
  localparam logic [4:0] OP_JZ   = 5'b11000;
  localparam logic [4:0] OP_JN   = 5'b11001;
  localparam logic [4:0] OP_JC   = 5'b11010;
  localparam logic [4:0] OP_JMP  = 5'b11011;
  localparam logic [4:0] OP_LDM  = 5'b10010;

  localparam int FLAG_Z = 0;
  localparam int FLAG_N = 1;
  localparam int FLAG_C = 2;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RESOLVE  = 2'd1,
    ST_WAIT_MEM = 2'd2,
    ST_INT_WAIT = 2'd3
  } redirect_state_t;

  // One-hot {C,N,Z} mask of the flag a conditional branch tests.
  function automatic logic [2:0] cond_mask(input logic [4:0] op);
    logic [2:0] m;
    m = 3'b000;
    case (op)
      OP_JZ:   m = 3'b001 << FLAG_Z;
      OP_JN:   m = 3'b001 << FLAG_N;
      OP_JC:   m = 3'b001 << FLAG_C;
      default: m = 3'b000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// mem_wait_timer: saturating up-counter bounding how long the redirect
// FSM waits for the memory stage.
// Ports:
//   clk     - clock, rising edge
//   rst_n   - asynchronous active-low reset
//   clear   - restart the count at 0 (wins over enable)
//   enable  - count one waiting cycle
//   expired - the cycle being counted brings the count to LIMIT
module mem_wait_timer #(
  parameter int              W     = 4,
  parameter logic [W-1:0]    LIMIT = 4'd15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [W-1:0] count;
  logic [W-1:0] count_inc;

  // Hold at LIMIT instead of wrapping.
  assign count_inc = (count == LIMIT) ? count : count + 1'b1;
  assign expired   = enable && (count_inc == LIMIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count_inc;
    end
  end

endmodule

// File: rtl/fetch_redirect_unit.sv
// fetch_redirect_unit: drives the redirect / stall / flush feedback into
// fetch and the IF/ID register for jmp, call, jz/jn/jc, ret, rti and
// interrupt entry. All outputs are registered.
// Ports:
//   i_clk, i_reset            - clock, async active-low reset
//   i_valid, i_hazard_instruction, i_opcode, i_reg_target - decode slot
//   i_flags                   - {C,N,Z} from execute, the cycle after i_valid
//   i_mem_valid, i_mem_data   - popped PC or vector word from memory
//   i_interrupt_signal        - external interrupt (level or pulse)
//   o_pc_new, o_branch_decision, o_stall, o_flush - fetch control
//   o_flag_clear, o_restore_flags - flag side effects
//   o_int_req, o_mem_addr     - interrupt entry request to memory
//   o_timeout                 - memory wait aborted
//
// state       | meaning
// ST_IDLE     | accept a hazard instruction or start interrupt entry
// ST_RESOLVE  | conditional branch waits one cycle for execute flags
// ST_WAIT_MEM | ret/rti waits for the popped PC
// ST_INT_WAIT | interrupt entry waits for the vector word
module fetch_redirect_unit
  import cpu_pkg::*;
#(
  parameter int              PC_W            = 32,
  parameter logic [PC_W-1:0] INT_VECTOR_ADDR = 32'h0000_0001,
  parameter int              MEM_TIMEOUT     = 15
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_valid,
  input  logic            i_hazard_instruction,
  input  logic [4:0]      i_opcode,
  input  logic [PC_W-1:0] i_reg_target,
  input  logic [2:0]      i_flags,
  input  logic            i_mem_valid,
  input  logic [PC_W-1:0] i_mem_data,
  input  logic            i_interrupt_signal,
  output logic [PC_W-1:0] o_pc_new,
  output logic            o_branch_decision,
  output logic            o_stall,
  output logic            o_flush,
  output logic [2:0]      o_flag_clear,
  output logic            o_restore_flags,
  output logic            o_int_req,
  output logic [PC_W-1:0] o_mem_addr,
  output logic            o_timeout
);

  redirect_state_t state;
  logic            int_pending;
  logic            int_prev;
  logic [PC_W-1:0] target_q;
  logic [4:0]      op_q;

  logic accept;
  logic int_rise;
  logic int_take;
  logic is_return;
  logic tmr_clear;
  logic tmr_enable;
  logic tmr_expired;

  assign accept     = (state == ST_IDLE) && i_valid && i_hazard_instruction;
  assign int_rise   = i_interrupt_signal && !int_prev;
  // An accepted hazard always beats a pending interrupt.
  assign int_take   = (state == ST_IDLE) && !accept && int_pending;
  assign is_return  = (i_opcode == OP_RET) || (i_opcode == OP_RTI);
  assign tmr_clear  = (accept && is_return) || int_take;
  assign tmr_enable = ((state == ST_WAIT_MEM) || (state == ST_INT_WAIT)) && !i_mem_valid;

  mem_wait_timer #(
    .W     (4),
    .LIMIT (4'(MEM_TIMEOUT))
  ) u_timer (
    .clk     (i_clk),
    .rst_n   (i_reset),
    .clear   (tmr_clear),
    .enable  (tmr_enable),
    .expired (tmr_expired)
  );

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state             <= ST_IDLE;
      int_pending       <= 1'b0;
      int_prev          <= 1'b0;
      target_q          <= '0;
      op_q              <= '0;
      o_pc_new          <= '0;
      o_branch_decision <= 1'b0;
      o_stall           <= 1'b0;
      o_flush           <= 1'b0;
      o_flag_clear      <= 3'b000;
      o_restore_flags   <= 1'b0;
      o_int_req         <= 1'b0;
      o_mem_addr        <= '0;
      o_timeout         <= 1'b0;
    end else begin
      int_prev          <= i_interrupt_signal;
      o_branch_decision <= 1'b0;
      o_flush           <= 1'b0;
      o_flag_clear      <= 3'b000;
      o_restore_flags   <= 1'b0;
      o_timeout         <= 1'b0;

      // Entry consumes the pending bit; an edge while pending is dropped.
      if (int_take) begin
        int_pending <= 1'b0;
      end else if (int_rise) begin
        int_pending <= 1'b1;
      end

      case (state)
        ST_IDLE: begin
          if (accept) begin
            op_q     <= i_opcode;
            target_q <= i_reg_target;
            case (i_opcode)
              OP_JMP, OP_CALL: begin
                o_pc_new          <= i_reg_target;
                o_branch_decision <= 1'b1;
                o_flush           <= 1'b1;
              end
              OP_JZ, OP_JN, OP_JC: begin
                state   <= ST_RESOLVE;
                o_stall <= 1'b1;
              end
              OP_RET, OP_RTI: begin
                state   <= ST_WAIT_MEM;
                o_stall <= 1'b1;
              end
              default: ;
            endcase
          end else if (int_take) begin
            state      <= ST_INT_WAIT;
            o_int_req  <= 1'b1;
            o_mem_addr <= INT_VECTOR_ADDR;
            o_stall    <= 1'b1;
          end
        end
        ST_RESOLVE: begin
          if ((i_flags & cond_mask(op_q)) != 3'b000) begin
            o_pc_new          <= target_q;
            o_branch_decision <= 1'b1;
            o_flush           <= 1'b1;
            o_flag_clear      <= cond_mask(op_q);
          end
          o_stall <= 1'b0;
          state   <= ST_IDLE;
        end
        ST_WAIT_MEM: begin
          if (i_mem_valid) begin
            o_pc_new          <= i_mem_data;
            o_branch_decision <= 1'b1;
            o_flush           <= 1'b1;
            o_restore_flags   <= (op_q == OP_RTI);
            o_stall           <= 1'b0;
            state             <= ST_IDLE;
          end else if (tmr_expired) begin
            o_timeout <= 1'b1;
            o_stall   <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        ST_INT_WAIT: begin
          if (i_mem_valid || tmr_expired) begin
            if (i_mem_valid) begin
              o_pc_new          <= i_mem_data;
              o_branch_decision <= 1'b1;
              o_flush           <= 1'b1;
            end else begin
              o_timeout <= 1'b1;
            end
            o_int_req  <= 1'b0;
            o_mem_addr <= '0;
            o_stall    <= 1'b0;
            state      <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_redirect_unit.sv
module tb_fetch_redirect_unit;
  import cpu_pkg::*;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic        i_valid;
  logic        i_hazard_instruction;
  logic [4:0]  i_opcode;
  logic [31:0] i_reg_target;
  logic [2:0]  i_flags;
  logic        i_mem_valid;
  logic [31:0] i_mem_data;
  logic        i_interrupt_signal;
  logic [31:0] o_pc_new;
  logic        o_branch_decision;
  logic        o_stall;
  logic        o_flush;
  logic [2:0]  o_flag_clear;
  logic        o_restore_flags;
  logic        o_int_req;
  logic [31:0] o_mem_addr;
  logic        o_timeout;

  int n_total = 0;
  int n_pass  = 0;

  fetch_redirect_unit dut (
    .i_clk                (i_clk),
    .i_reset              (i_reset),
    .i_valid              (i_valid),
    .i_hazard_instruction (i_hazard_instruction),
    .i_opcode             (i_opcode),
    .i_reg_target         (i_reg_target),
    .i_flags              (i_flags),
    .i_mem_valid          (i_mem_valid),
    .i_mem_data           (i_mem_data),
    .i_interrupt_signal   (i_interrupt_signal),
    .o_pc_new             (o_pc_new),
    .o_branch_decision    (o_branch_decision),
    .o_stall              (o_stall),
    .o_flush              (o_flush),
    .o_flag_clear         (o_flag_clear),
    .o_restore_flags      (o_restore_flags),
    .o_int_req            (o_int_req),
    .o_mem_addr           (o_mem_addr),
    .o_timeout            (o_timeout)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic issue(input logic [4:0] op, input logic [31:0] tgt);
    i_valid              = 1'b1;
    i_hazard_instruction = 1'b1;
    i_opcode             = op;
    i_reg_target         = tgt;
  endtask

  task automatic quiet();
    i_valid              = 1'b0;
    i_hazard_instruction = 1'b0;
    i_opcode             = 5'b00000;
    i_reg_target         = 32'h0;
    i_mem_valid          = 1'b0;
    i_flags              = 3'b000;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_br"},    32'(o_branch_decision), 32'd0);
    chk({tag, "_stall"}, 32'(o_stall),           32'd0);
    chk({tag, "_flush"}, 32'(o_flush),           32'd0);
    chk({tag, "_pc"},    o_pc_new,               32'h0);
    chk({tag, "_intr"},  32'(o_int_req),         32'd0);
    chk({tag, "_maddr"}, o_mem_addr,             32'h0);
    chk({tag, "_tmo"},   32'(o_timeout),         32'd0);
    chk({tag, "_fclr"},  32'(o_flag_clear),      32'd0);
    chk({tag, "_rst"},   32'(o_restore_flags),   32'd0);
  endtask

  initial begin
    i_reset            = 1'b0;
    i_mem_data         = 32'h0;
    i_interrupt_signal = 1'b0;
    quiet();
    #3;
    chk_all_zero("reset");
    @(posedge i_clk); #1;
    i_reset = 1'b1;
    step();

    // jmp: one-cycle redirect, no stall
    issue(OP_JMP, 32'h40);
    step();
    chk("jmp_br",    32'(o_branch_decision), 32'd1);
    chk("jmp_pc",    o_pc_new,               32'h40);
    chk("jmp_flush", 32'(o_flush),           32'd1);
    chk("jmp_stall", 32'(o_stall),           32'd0);
    quiet();
    step();
    chk("jmp_br_off",    32'(o_branch_decision), 32'd0);
    chk("jmp_flush_off", 32'(o_flush),           32'd0);

    // ldm: passes through with nothing
    issue(OP_LDM, 32'h77);
    step();
    chk("ldm_br",    32'(o_branch_decision), 32'd0);
    chk("ldm_stall", 32'(o_stall),           32'd0);
    quiet();

    // jz taken
    issue(OP_JZ, 32'h80);
    step();
    chk("jz_stall", 32'(o_stall),           32'd1);
    chk("jz_br0",   32'(o_branch_decision), 32'd0);
    quiet();
    i_flags = 3'b001;
    step();
    chk("jz_br",    32'(o_branch_decision), 32'd1);
    chk("jz_pc",    o_pc_new,               32'h80);
    chk("jz_fclr",  32'(o_flag_clear),      32'd1);
    chk("jz_flush", 32'(o_flush),           32'd1);
    chk("jz_stall_off", 32'(o_stall),       32'd0);
    i_flags = 3'b000;
    step();
    chk("jz_br_off",   32'(o_branch_decision), 32'd0);
    chk("jz_fclr_off", 32'(o_flag_clear),      32'd0);

    // jc not taken with only Z set
    issue(OP_JC, 32'h90);
    step();
    chk("jc_stall", 32'(o_stall), 32'd1);
    quiet();
    i_flags = 3'b001;
    step();
    chk("jc_br",    32'(o_branch_decision), 32'd0);
    chk("jc_fclr",  32'(o_flag_clear),      32'd0);
    chk("jc_stall_off", 32'(o_stall),       32'd0);
    i_flags = 3'b000;

    // jn taken with N set
    issue(OP_JN, 32'hA0);
    step();
    quiet();
    i_flags = 3'b010;
    step();
    chk("jn_br",   32'(o_branch_decision), 32'd1);
    chk("jn_pc",   o_pc_new,               32'hA0);
    chk("jn_fclr", 32'(o_flag_clear),      32'd2);
    i_flags = 3'b000;

    // rti with memory answering on the third wait cycle
    issue(OP_RTI, 32'h0);
    step();
    chk("rti_stall1", 32'(o_stall), 32'd1);
    quiet();
    step();
    chk("rti_stall2", 32'(o_stall), 32'd1);
    step();
    chk("rti_stall3", 32'(o_stall), 32'd1);
    chk("rti_br0",    32'(o_branch_decision), 32'd0);
    i_mem_valid = 1'b1;
    i_mem_data  = 32'h123;
    step();
    chk("rti_br",    32'(o_branch_decision), 32'd1);
    chk("rti_pc",    o_pc_new,               32'h123);
    chk("rti_rest",  32'(o_restore_flags),   32'd1);
    chk("rti_flush", 32'(o_flush),           32'd1);
    chk("rti_stall_off", 32'(o_stall),       32'd0);
    quiet();
    step();
    chk("rti_rest_off", 32'(o_restore_flags),   32'd0);
    chk("rti_br_off",   32'(o_branch_decision), 32'd0);

    // interrupt edge together with a call: call first, then entry
    issue(OP_CALL, 32'h300);
    i_interrupt_signal = 1'b1;
    step();
    chk("call_br",   32'(o_branch_decision), 32'd1);
    chk("call_pc",   o_pc_new,               32'h300);
    chk("call_intr", 32'(o_int_req),         32'd0);
    quiet();
    step();
    chk("int_req",   32'(o_int_req),         32'd1);
    chk("int_maddr", o_mem_addr,             32'h1);
    chk("int_stall", 32'(o_stall),           32'd1);
    chk("int_br0",   32'(o_branch_decision), 32'd0);
    step();
    chk("int_req_hold", 32'(o_int_req), 32'd1);
    i_mem_valid = 1'b1;
    i_mem_data  = 32'h200;
    step();
    chk("int_br",    32'(o_branch_decision), 32'd1);
    chk("int_pc",    o_pc_new,               32'h200);
    chk("int_flush", 32'(o_flush),           32'd1);
    chk("int_req_off",   32'(o_int_req),     32'd0);
    chk("int_maddr_off", o_mem_addr,         32'h0);
    chk("int_stall_off", 32'(o_stall),       32'd0);
    quiet();
    i_interrupt_signal = 1'b0;
    step();
    chk("int_once_br",  32'(o_branch_decision), 32'd0);
    step();
    chk("int_once_req", 32'(o_int_req),         32'd0);

    // ret with no memory answer: 15 stalled cycles then timeout
    issue(OP_RET, 32'h0);
    step();
    quiet();
    chk("tmo_stall_0", 32'(o_stall), 32'd1);
    for (int i = 1; i < 15; i++) begin
      step();
      chk($sformatf("tmo_stall_%0d", i), 32'(o_stall),   32'd1);
      chk($sformatf("tmo_early_%0d", i), 32'(o_timeout), 32'd0);
    end
    step();
    chk("tmo_pulse",     32'(o_timeout),         32'd1);
    chk("tmo_stall_off", 32'(o_stall),           32'd0);
    chk("tmo_br",        32'(o_branch_decision), 32'd0);
    i_mem_valid = 1'b1;
    i_mem_data  = 32'h999;
    step();
    chk("tmo_pulse_off", 32'(o_timeout),         32'd0);
    chk("tmo_late_mem",  32'(o_branch_decision), 32'd0);
    quiet();

    // asynchronous reset in the middle of a ret wait
    issue(OP_RET, 32'h0);
    step();
    chk("rstw_stall", 32'(o_stall), 32'd1);
    quiet();
    step();
    #2;
    i_reset = 1'b0;
    #1;
    chk_all_zero("rstw");
    @(posedge i_clk); #1;
    i_reset     = 1'b1;
    i_mem_valid = 1'b1;
    i_mem_data  = 32'h555;
    step();
    chk("rstw_mem_br",    32'(o_branch_decision), 32'd0);
    chk("rstw_mem_stall", 32'(o_stall),           32'd0);
    quiet();
    step();
    chk("rstw_idle_br", 32'(o_branch_decision), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/fetch_redirect_unit.md
Name: fetch_redirect_unit

Overview:
- Owns the feedback path into fetch: generates the PC redirect (new PC plus branch decision), the stall, and the flush seen by the fetch stage and the IF/ID register.
- Consumes the hazard flag and opcode of the instruction in decode, the flags from execute, register/memory targets, and the external interrupt line.
- Resolves jmp/call/jz/jn/jc/ret/rti and the interrupt entry sequence with a small FSM.
- Sits between the decode, execute and memory stages and the fetch stage.

Parameters:
PC_W, 32, program-counter / target width
INT_VECTOR_ADDR, 32'h0000_0001, data-memory address of the interrupt vector, driven on o_mem_addr during interrupt entry
MEM_TIMEOUT, 15, max cycles to wait for i_mem_valid before aborting (4-bit counter)

Ports:
i_clk  in  1  clock, rising edge
i_reset  in  1  asynchronous, active-low reset (0 = reset)
i_valid  in  1  instruction in decode is valid
i_hazard_instruction  in  1  decode instruction is a hazard type (call/ret/rti/jz/jn/jc/jmp/ldm)
i_opcode  in  5  opcode of the decode instruction
i_reg_target  in  PC_W  Rdst value (jump/call target), valid with i_valid
i_flags  in  3  {C,N,Z} from execute, valid the cycle after i_valid
i_mem_valid  in  1  memory stage returns popped PC / vector word
i_mem_data  in  PC_W  popped PC (ret/rti) or vector contents
i_interrupt_signal  in  1  external interrupt, level or pulse
o_pc_new  out  PC_W  redirect target to fetch
o_branch_decision  out  1  one-cycle redirect strobe
o_stall  out  1  freeze PC and IF/ID
o_flush  out  1  squash IF/ID contents
o_flag_clear  out  3  one-cycle clear mask {C,N,Z} for a taken conditional
o_restore_flags  out  1  one-cycle pulse: rti restores saved flags
o_int_req  out  1  interrupt entry: memory pushes PC and reads vector
o_mem_addr  out  PC_W  INT_VECTOR_ADDR while o_int_req, else 0
o_timeout  out  1  one-cycle pulse on memory-wait abort

Behaviour:
- All outputs registered. Reset (i_reset=0, async) forces state IDLE, the pending-interrupt bit to 0, the counter to 0 and every output to 0.
- Opcodes: call 00101, ret 00010, rti 00011, jz 11000, jn 11001, jc 11010, jmp 11011, ldm 10010.
- A new instruction is accepted only in IDLE with i_valid & i_hazard_instruction; any other i_valid is ignored.
- Interrupt: a rising level sets int_pending; it stays set until entry starts, and a second edge while pending is dropped.
- States: IDLE, RESOLVE, WAIT_MEM, INT_WAIT.
- IDLE, jmp/call: next cycle o_pc_new=i_reg_target, o_branch_decision=1, o_flush=1 (one cycle); stays IDLE. Redirect latency is 1 cycle.
- IDLE, jz/jn/jc: enter RESOLVE; o_stall=1 next cycle; target latched.
- RESOLVE: sample i_flags. If the tested bit (Z/N/C) is 1: redirect pulse, o_flush=1, o_flag_clear sets that one bit. Otherwise no redirect. o_stall drops. Return to IDLE. Total 2 cycles.
- IDLE, ret/rti: enter WAIT_MEM; o_stall=1 and the counter cleared.
- WAIT_MEM: on i_mem_valid, redirect to i_mem_data with o_flush=1; rti also pulses o_restore_flags. Return to IDLE.
- WAIT_MEM timeout: if the counter reaches MEM_TIMEOUT without i_mem_valid, pulse o_timeout, release the stall with no redirect, and return to IDLE. The counter saturates and never wraps.
- IDLE, ldm: no redirect and no stall; the immediate word passes normally.
- Interrupt entry: taken only in IDLE when the decode slot holds no accepted hazard that cycle. Clear int_pending, enter INT_WAIT, and set o_int_req=1, o_mem_addr=INT_VECTOR_ADDR, o_stall=1.
- INT_WAIT: on i_mem_valid, redirect to i_mem_data with o_flush=1 and return to IDLE. Timeout is handled as in WAIT_MEM.
- Simultaneous hazard and pending interrupt in IDLE: the hazard wins and the interrupt stays pending. An interrupt during RESOLVE, WAIT_MEM or INT_WAIT is latched, not serviced.
- i_mem_valid outside WAIT_MEM/INT_WAIT is ignored.
- Reset mid-operation: immediate return to IDLE with outputs 0; a pending interrupt is lost.
- o_branch_decision and o_flush are never high for more than 1 consecutive cycle. o_stall is never high in the cycle o_branch_decision pulses.

Decomposition:
- Shared package (cpu_pkg) holds the opcode constants (OP_CALL, OP_RET, OP_RTI, OP_JZ, OP_JN, OP_JC, OP_JMP, OP_LDM), the flag bit indices (FLAG_Z=0, FLAG_N=1, FLAG_C=2) and the state encoding, so the fetch and decode stages use the same values.
- One sub-module: mem_wait_timer, the saturating counter with clear/enable/expired outputs.

Test Plan:
- Reset during WAIT_MEM (i_reset=0 mid-wait) -> all outputs 0 asynchronously, state IDLE; a later i_mem_valid with no new instruction causes no redirect.
- jmp with i_reg_target=32'h40 -> exactly 1 cycle later o_branch_decision=1, o_pc_new=32'h40, o_flush=1, each for one cycle; o_stall stays 0.
- jz taken (i_flags=3'b001 in RESOLVE), target 32'h80 -> o_stall=1 for 1 cycle, then redirect to 32'h80 with o_flag_clear=3'b001. jc with i_flags=3'b001 -> no redirect, o_flag_clear=0.
- rti, i_mem_valid 3 cycles later with i_mem_data=32'h123 -> o_stall held 3 cycles, then redirect to 32'h123 with o_restore_flags=1 for one cycle.
- Interrupt edge in the same cycle as an accepted call -> the call redirect occurs first. Next IDLE cycle: o_int_req=1, o_mem_addr=32'h1. i_mem_data=32'h200 -> redirect to 32'h200.
- ret with no i_mem_valid -> after 15 wait cycles o_timeout=1 for one cycle, o_stall=0, no redirect, back to IDLE.
